// File: rtl/twofish_pkg.sv
// rtl/twofish_pkg.sv - shared types and constants for the Twofish round sequencer
package twofish_pkg;

  localparam int NUM_ROUNDS      = 16;
  localparam int IN_WHITEN_BASE  = 0;
  localparam int OUT_WHITEN_BASE = 4;
  localparam int ROUND_KEY_BASE  = 8;

  typedef logic [31:0] word_t;
  typedef word_t [3:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } seq_state_e;

endpackage

// File: rtl/twofish_whiten.sv
// rtl/twofish_whiten.sv - word-wise 128-bit key XOR with optional 64-bit half swap
module twofish_whiten
  import twofish_pkg::*;
(
  input  block_t data,
  input  block_t key,
  input  logic   swap,
  output block_t result
);

  // swap exchanges the two 64-bit halves before XOR, undoing the last Feistel swap
  for (genvar i = 0; i < 4; i++) begin : g_word
    assign result[i] = (swap ? data[(i + 2) % 4] : data[i]) ^ key[i];
  end

endmodule

// File: rtl/twofish_round_seq.sv
// rtl/twofish_round_seq.sv - iterative Twofish encryption sequencer around an external round datapath
module twofish_round_seq
  import twofish_pkg::*;
#(
  parameter int ROUNDS = NUM_ROUNDS,
  parameter int RCW    = $clog2(ROUNDS),
  parameter int KIW    = $clog2(2 * ROUNDS + 10)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     wk_in,
  input  logic [127:0]     wk_out,
  output logic [KIW-1:0]   key_idx,
  input  logic [31:0]      key_even,
  input  logic [31:0]      key_odd,
  output logic [127:0]     dp_state_o,
  output logic [31:0]      dp_k0,
  output logic [31:0]      dp_k1,
  input  logic [127:0]     dp_state_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic [RCW-1:0]   rnd
);

  seq_state_e state_q, state_d;
  block_t     blk_q;
  block_t     in_white;
  block_t     out_white;
  logic       accept;
  logic       last_round;

  twofish_whiten u_in_whiten (
    .data   (in_data),
    .key    (wk_in),
    .swap   (1'b0),
    .result (in_white)
  );

  twofish_whiten u_out_whiten (
    .data   (dp_state_i),
    .key    (wk_out),
    .swap   (1'b1),
    .result (out_white)
  );

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign last_round = (rnd == RCW'(ROUNDS - 1));
  assign busy       = (state_q == ROUND);
  assign key_idx    = KIW'({rnd, 1'b0}) + KIW'(ROUND_KEY_BASE);
  assign dp_state_o = blk_q;
  assign dp_k0      = key_even;
  assign dp_k1      = key_odd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      rnd       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q <= in_white;
        rnd   <= '0;
      end else if (state_q == ROUND) begin
        blk_q <= dp_state_i;
        if (!last_round) rnd <= rnd + 1'b1;
      end
      // any consumer handshake retires the held result, including the back-to-back case
      if ((state_q == ROUND) && last_round) begin
        out_data  <= out_white;
        out_valid <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twofish_round_seq.sv
// tb/tb_twofish_round_seq.sv - self-checking bench for twofish_round_seq
module tb_twofish_round_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] wk_in;
  logic [127:0] wk_out;
  logic [5:0]   key_idx;
  logic [31:0]  key_even;
  logic [31:0]  key_odd;
  logic [127:0] dp_state_o;
  logic [31:0]  dp_k0;
  logic [31:0]  dp_k1;
  logic [127:0] dp_state_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   rnd;

  logic [31:0]  kseed;
  logic         ident;
  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  twofish_round_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wk_in      (wk_in),
    .wk_out     (wk_out),
    .key_idx    (key_idx),
    .key_even   (key_even),
    .key_odd    (key_odd),
    .dp_state_o (dp_state_o),
    .dp_k0      (dp_k0),
    .dp_k1      (dp_k1),
    .dp_state_i (dp_state_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .rnd        (rnd)
  );

  function automatic logic [31:0] kf(input logic [5:0] idx, input logic [31:0] seed);
    return ((32'(idx) + 32'd1) * 32'h9E3779B9) ^ seed;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // stand-in round: mixes the low half into the high half, then swaps halves
  function automatic logic [127:0] toy(input logic [127:0] s, input logic [31:0] k0, input logic [31:0] k1);
    logic [31:0] w0, w1, w2, w3, f0, f1;
    w0 = s[31:0]; w1 = s[63:32]; w2 = s[95:64]; w3 = s[127:96];
    f0 = rotl(w0 + k0, 3) ^ w1;
    f1 = rotl(w1 + k1 + w0, 7);
    return {w1, w0, w3 ^ f1, w2 ^ f0};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] pt, input logic [127:0] wki,
                                         input logic [127:0] wko, input logic [31:0] seed,
                                         input logic id);
    logic [127:0] s;
    s = pt ^ wki;
    for (int r = 0; r < 16; r++)
      if (!id) s = toy(s, kf(6'(2 * r + 8), seed), kf(6'(2 * r + 9), seed));
    return {s[63:0], s[127:64]} ^ wko;
  endfunction

  assign key_even   = kf(key_idx, kseed);
  assign key_odd    = kf(key_idx + 6'd1, kseed);
  assign dp_state_i = ident ? dp_state_o : toy(dp_state_o, dp_k0, dp_k1);

  task automatic check(input logic ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(in_data, wk_in, wk_out, kseed, ident));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check(1'b0, "sb_underflow", out_data, '0);
        else begin
          logic [127:0] e;
          e = sb.pop_front();
          check(out_data === e, "sb_data", out_data, e);
        end
      end
    end
  end

  // drives one block from IDLE; returns at the negedge where out_valid is first seen
  task automatic run_block(input logic [127:0] pt, input logic [127:0] wki,
                           input logic [127:0] wko, output logic [127:0] res);
    int   n;
    logic seq_ok;
    @(posedge clk); #1;
    in_data = pt; wk_in = wki; wk_out = wko; in_valid = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1, "in_ready_idle", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {4{$urandom}}; wk_in = {4{$urandom}};
    @(negedge clk);
    seq_ok = busy && rnd == 4'd0 && key_idx == 6'd8;
    for (n = 1; n < 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) break;
      if (!(busy && rnd == 4'(n) && key_idx == 6'(2 * n + 8))) seq_ok = 1'b0;
    end
    check(n == 16, "latency", 128'(n), 128'd16);
    check(seq_ok, "key_idx_seq", 128'(seq_ok), 128'd1);
    check(busy === 1'b0, "busy_clear", 128'(busy), 128'd0);
    res = out_data;
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] wki;
    logic [127:0] wko;
    logic [31:0]  seed;
    logic         id;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] res, held, b1, b2;
  logic         ok;
  int           n;

  initial begin
    vecs[0] = '{128'h0, 128'h0, 128'h0, 32'h0, 1'b0, 128'h0};
    vecs[1] = '{128'h0, 128'h11111111_22222222_33333333_44444444, 128'h0, 32'h0, 1'b1,
                128'h33333333_44444444_11111111_22222222};
    vecs[2] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678, 32'h5A5A1234, 1'b0, 128'h0};
    vecs[3] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h0, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                32'hFFFFFFFF, 1'b0, 128'h0};
    vecs[4] = '{128'h80000000_00000001_00000000_00000080, 128'h0F0F0F0F_F0F0F0F0_AAAAAAAA_55555555,
                128'h11111111_22222222_33333333_44444444, 32'h00000001, 1'b1, 128'h0};
    for (int i = 0; i < 5; i++)
      if (i != 1) vecs[i].exp = model(vecs[i].pt, vecs[i].wki, vecs[i].wko, vecs[i].seed, vecs[i].id);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; wk_in = '0; wk_out = '0;
    out_ready = 1'b1; kseed = '0; ident = 1'b0;
    #12;
    check(out_valid === 1'b0, "rst_out_valid", 128'(out_valid), 128'd0);
    check(out_data === '0, "rst_out_data", out_data, '0);
    check(busy === 1'b0, "rst_busy", 128'(busy), 128'd0);
    check(rnd === 4'd0, "rst_rnd", 128'(rnd), 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1, "rst_in_ready", 128'(in_ready), 128'd1);

    for (int i = 0; i < 5; i++) begin
      kseed = vecs[i].seed; ident = vecs[i].id; out_ready = 1'b1;
      run_block(vecs[i].pt, vecs[i].wki, vecs[i].wko, res);
      check(res === vecs[i].exp, "vec", res, vecs[i].exp);
    end

    // consumer stall: result held, new input refused
    kseed = 32'h13579BDF; ident = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    run_block(vecs[2].pt, vecs[3].wki, vecs[2].wko, held);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 in_valid = c[0]; in_data = {4{$urandom}};
      @(negedge clk);
      if (!(out_valid && out_data == held && !in_ready && !busy)) ok = 1'b0;
    end
    check(ok, "stall_hold", out_data, held);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check(out_valid === 1'b0 && in_ready === 1'b1, "stall_release", 128'(out_valid), 128'd0);

    // back-to-back: second block accepted in the first DONE cycle
    b1 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    b2 = 128'h0BADF00D_DEADBEEF_FEEDFACE_01020304;
    @(posedge clk); #1 in_data = b1; wk_in = vecs[2].wki; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1 in_data = b2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check(out_valid === 1'b1 && in_ready === 1'b1, "b2b_done", 128'(out_valid), 128'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check(busy === 1'b1 && rnd === 4'd0 && out_valid === 1'b0, "b2b_no_bubble", 128'(busy), 128'd1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check(out_valid === 1'b0, "b2b_not_early", 128'(out_valid), 128'd0);
    @(posedge clk); @(negedge clk);
    check(out_valid === 1'b1, "b2b_latency", 128'(out_valid), 128'd1);
    check(out_data === model(b2, vecs[2].wki, wk_out, kseed, ident), "b2b_data", out_data,
          model(b2, vecs[2].wki, wk_out, kseed, ident));

    // reset mid-block
    @(posedge clk); #1 in_data = b1; wk_in = '0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rnd == 4'd7) break;
    end
    check(n < 20, "reach_rnd7", 128'(n), 128'd7);
    #2 rst_n = 1'b0;
    #1;
    check(out_valid === 1'b0 && busy === 1'b0 && rnd === 4'd0, "abort_state", 128'(busy), 128'd0);
    check(out_data === '0, "abort_out_data", out_data, '0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1 && out_valid === 1'b0, "post_rst_ready", 128'(in_ready), 128'd1);
    run_block(b2, vecs[4].wki, vecs[3].wko, res);
    check(res === model(b2, vecs[4].wki, vecs[3].wko, kseed, ident), "post_rst_data", res,
          model(b2, vecs[4].wki, vecs[3].wko, kseed, ident));
    @(posedge clk); #1;
    @(negedge clk);
    check(sb.size() == 0, "sb_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/twofish_round_seq.md
Name: twofish_round_seq

Overview:
Iterative Twofish encryption sequencer. Accepts one 128-bit plaintext block per transaction and applies input whitening. It then drives the existing combinational one-round datapath for ROUNDS cycles, supplying state and round subkeys. Finally it applies the final swap-undo and output whitening, and returns the ciphertext over a valid/ready handshake. It sits between the block-level stream interface and the round datapath / key schedule.

Parameters:
ROUNDS, 16, number of Feistel rounds; must be even and >= 2.
RCW, $clog2(ROUNDS), round counter width.
KIW, $clog2(2*ROUNDS+10), width of key_idx.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext valid
in_ready  out  1  block can accept plaintext this cycle
in_data  in  128  plaintext, word0 = [31:0] … word3 = [127:96]
wk_in  in  128  input whitening keys K0..K3, same word order
wk_out  in  128  output whitening keys K4..K7, same word order
key_idx  out  KIW  index of even round subkey = 2*rnd+8
key_even  in  32  K[key_idx], combinational from key schedule, same cycle
key_odd  in  32  K[key_idx+1], combinational, same cycle
dp_state_o  out  128  {R3,R2,R1,R0} to round datapath
dp_k0  out  32  = key_even, passed to datapath K0
dp_k1  out  32  = key_odd, passed to datapath K1
dp_state_i  in  128  datapath result {c3,c2,r1,r0}, combinational
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer accepts ciphertext
out_data  out  128  ciphertext
busy  out  1  high in ROUND state
rnd  out  RCW  current round number

Behaviour:
- Reset (async, rst_n=0) forces the following, independent of clk:
  - state=IDLE, rnd=0, state regs=0, out_data=0, out_valid=0, busy=0.
  - in_ready=1 once rst_n is high.
- FSM states: IDLE, ROUND, DONE.
- in_ready = (IDLE) | (DONE & out_ready). Acceptance = in_valid & in_ready.
- On acceptance:
  - state regs <= in_data ^ wk_in, word-wise.
  - rnd <= 0; next state ROUND.
- ROUND, each edge:
  - state regs <= dp_state_i, i.e. the datapath already performs the half swap.
  - If rnd == ROUNDS-1: next DONE and out_data <= {r1^K7, r0^K6, c3^K5, c2^K4}, taken from dp_state_i. This undoes the last swap and applies output whitening; out_valid <= 1.
  - Otherwise rnd <= rnd+1.
- key_idx = 2*rnd+8 in every state; it is meaningful only in ROUND. dp_k0/dp_k1 are pure wires.
- Latency: out_valid rises on the ROUNDS-th rising edge after the acceptance edge (16 for default).
- DONE:
  - out_data and out_valid are held stable until out_ready=1.
  - On the handshake, next state is ROUND if a new block is accepted the same cycle (back-to-back, no bubble). Otherwise it is IDLE with out_valid <= 0.
- in_valid while in ROUND is ignored: in_ready=0 and no state change.
- in_data and wk_in are sampled only at the acceptance edge. wk_out is sampled only at the final round edge. Changes at any other time have no effect.
- key_even/key_odd must be valid the same cycle key_idx is driven; no wait states.
- Reset mid-ROUND aborts the block: no output is produced and no partial out_valid is issued.
- All XORs are 32-bit word-wise with no carries. The word order above is normative.

Decomposition:
- Package twofish_pkg holds:
  - NUM_ROUNDS=16, IN_WHITEN_BASE=0, OUT_WHITEN_BASE=4, ROUND_KEY_BASE=8.
  - typedef word_t (32 bits), block_t (4×word_t).
  - enum seq_state_e {IDLE, ROUND, DONE}.
- One sub-module: twofish_whiten. It is a combinational 128-bit word-wise XOR with an optional half-swap select, and is used for both input and output whitening.
- The round datapath stays outside this block.

Test Plan:
- Zero key, zero plaintext, with key_even/key_odd and S-words from the reference model → out_data = 9F589F5C_F6122C32_B6BFEC2F_2AE8C35A (byte-mapped per model); out_valid exactly 16 edges after acceptance.
- Monitor key_idx during ROUND → sequence 8,10,12,…,38, one per cycle; busy=1 for exactly 16 cycles; rnd 0..15.
- Hold out_ready=0 for 5 cycles after out_valid → out_data and out_valid unchanged; in_ready=0; in_valid pulses ignored.
- out_ready=1 and in_valid=1 in the first DONE cycle → the second block is accepted with no idle cycle; its result appears 16 edges later and equals the model.
- Assert rst_n=0 at rnd=7 → immediate IDLE, out_valid=0, out_data=0. After release, in_ready=1 and a fresh block encrypts correctly.
- Stub datapath as identity (dp_state_i=dp_state_o); in_data=0x0…0, wk_in=0x11111111_22222222_33333333_44444444, wk_out=0 → out_data words show the swapped whitened input, checking word-order mapping.
